// File: rtl/vga_keyboard_renderer_if.sv
// Video output bundle of the keyboard renderer.
//   oVGA_Hsync/oVGA_Vsync : sync outputs (polarity set by the renderer)
//   oVGA_Red/Green/Blue   : 4-bit colour channels
//   oDe                   : display enable, aligned with RGB
//   oFrameStart           : one-cycle pulse on pixel (0,0)
// master = renderer side (drives), slave = sink side (observes).
interface vga_keyboard_renderer_if;
  logic       oVGA_Hsync;
  logic       oVGA_Vsync;
  logic [3:0] oVGA_Red;
  logic [3:0] oVGA_Green;
  logic [3:0] oVGA_Blue;
  logic       oDe;
  logic       oFrameStart;

  modport master (output oVGA_Hsync, oVGA_Vsync, oVGA_Red, oVGA_Green, oVGA_Blue, oDe, oFrameStart);
  modport slave  (input  oVGA_Hsync, oVGA_Vsync, oVGA_Red, oVGA_Green, oVGA_Blue, oDe, oFrameStart);
endinterface

// File: rtl/vga_keyboard_renderer.sv
// VGA timing generator plus piano keyboard / progress-bar pixel renderer.
// Ports:
//   iClk        : pixel clock (generated elsewhere)
//   iReset_n    : asynchronous active-low reset
//   iWhiteMask  : bit k = white key k pressed
//   iBlackMask  : bit k = black key right of white key k pressed
//   iProgress   : song progress in percent (clamped to 100)
//   vga         : video output bundle (master modport)
// Pipeline: counters -> region/key decode -> colour register; sync, DE and
// frame-start ride along so every output is 2 cycles behind the counters.
// Inputs are latched once per frame at counter (0,0) so a frame never tears.
// Optional macro VGA_KEY_HOLD_EN: per-key highlight hold of HOLD_FRAMES frames.

`ifdef VGA_KEY_HOLD_EN
// One key's hold countdown: reload while pressed, count down while released.
module vga_keyboard_hold #(
  parameter int HOLD_FRAMES = 8
) (
  input  logic iClk,
  input  logic iReset_n,
  input  logic iTick,
  input  logic iSet,
  output logic oHi
);
  localparam int W = $clog2(HOLD_FRAMES + 1);
  logic [W-1:0] cnt;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n)         cnt <= '0;
    else if (iTick) begin
      if (iSet)            cnt <= W'(HOLD_FRAMES);
      else if (cnt != '0)  cnt <= cnt - 1'b1;
    end
  end

  assign oHi = (cnt != '0);
endmodule
`endif

module vga_keyboard_renderer #(
  parameter int   H_DISP      = 1024,
  parameter int   H_FRONT     = 24,
  parameter int   H_SYNC      = 136,
  parameter int   H_BACK      = 160,
  parameter int   V_DISP      = 768,
  parameter int   V_FRONT     = 3,
  parameter int   V_SYNC      = 6,
  parameter int   V_BACK      = 29,
  parameter logic SYNC_POL    = 1'b1,
  parameter int   KEY_COUNT   = 49,
  parameter int   KEY_W       = 19,
  parameter int   KEY_GAP     = 5,
  parameter int   KEY_X0      = 20,
  parameter int   KEY_Y0      = 200,
  parameter int   KEY_H       = 160,
  parameter int   BLACK_W     = 10,
  parameter int   BLACK_H     = 80,
  parameter int   BAR_X0      = 20,
  parameter int   BAR_Y0      = 120,
  parameter int   BAR_W       = 900,
  parameter int   BAR_H       = 40,
  parameter int   HOLD_FRAMES = 8
) (
  input  logic                 iClk,
  input  logic                 iReset_n,
  input  logic [KEY_COUNT-1:0] iWhiteMask,
  input  logic [KEY_COUNT-1:0] iBlackMask,
  input  logic [7:0]           iProgress,
  vga_keyboard_renderer_if.master vga
);
  localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int KW      = $clog2(KEY_COUNT + 1);
  localparam int OW      = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int STAGES  = 2;
  localparam int KEY_X1  = KEY_X0 + KEY_COUNT * KEY_W;
  // A black key straddles a white-key boundary: its left half covers the
  // last BLACK_W/2 columns of key k, its right half the first columns of k+1.
  localparam int BLK_R   = KEY_W - BLACK_W / 2;
  localparam int BLK_L   = BLACK_W - BLACK_W / 2;

  // ---- stage 0: raster counters ----
  logic [HW-1:0] hCnt;
  logic [VW-1:0] vCnt;
  logic [31:0]   hPos, vPos;
  logic          frameTop;

  assign hPos     = 32'(hCnt);
  assign vPos     = 32'(vCnt);
  assign frameTop = (hCnt == '0) && (vCnt == '0);

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (hPos == H_TOTAL - 1) begin
      hCnt <= '0;
      vCnt <= (vPos == V_TOTAL - 1) ? '0 : vCnt + 1'b1;
    end else begin
      hCnt <= hCnt + 1'b1;
    end
  end

  logic          vis0, hs0, vs0, kbY0, blkY0, kbX0, bar0;
  logic [BW-1:0] barOff0;

  assign vis0    = (hPos < H_DISP) && (vPos < V_DISP);
  assign hs0     = (hPos >= H_DISP + H_FRONT) && (hPos < H_DISP + H_FRONT + H_SYNC);
  assign vs0     = (vPos >= V_DISP + V_FRONT) && (vPos < V_DISP + V_FRONT + V_SYNC);
  assign kbY0    = (vPos >= KEY_Y0) && (vPos < KEY_Y0 + KEY_H);
  assign blkY0   = (vPos >= KEY_Y0) && (vPos < KEY_Y0 + BLACK_H);
  assign kbX0    = (hPos >= KEY_X0) && (hPos < KEY_X1);
  assign bar0    = (hPos >= BAR_X0) && (hPos < BAR_X0 + BAR_W) &&
                   (vPos >= BAR_Y0) && (vPos < BAR_Y0 + BAR_H);
  assign barOff0 = BW'(hPos - BAR_X0);

  // ---- stage 1: region flags and incremental key column tracking ----
  logic [STAGES:1] dePipe, hsPipe, vsPipe, fsPipe;
  logic            kbY1, blkY1, kbX1, bar1;
  logic [BW-1:0]   barOff1;
  logic [OW-1:0]   keyOff;   // column within current white key
  logic [KW-1:0]   keyIdx;   // white key index, saturates at KEY_COUNT
  logic [2:0]      note;     // keyIdx mod 7, tracked alongside keyIdx
  logic [31:0]     off32, idx32;

  assign off32 = 32'(keyOff);
  assign idx32 = 32'(keyIdx);

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      dePipe  <= '0;
      hsPipe  <= '0;
      vsPipe  <= '0;
      fsPipe  <= '0;
      kbY1    <= 1'b0;
      blkY1   <= 1'b0;
      kbX1    <= 1'b0;
      bar1    <= 1'b0;
      barOff1 <= '0;
      keyOff  <= '0;
      keyIdx  <= '0;
      note    <= '0;
    end else begin
      dePipe  <= {dePipe[STAGES-1:1], vis0};
      hsPipe  <= {hsPipe[STAGES-1:1], hs0};
      vsPipe  <= {vsPipe[STAGES-1:1], vs0};
      fsPipe  <= {fsPipe[STAGES-1:1], frameTop};
      kbY1    <= kbY0;
      blkY1   <= blkY0;
      kbX1    <= kbX0;
      bar1    <= bar0;
      barOff1 <= barOff0;
      // Restart at the keyboard's left edge every line; outside the keyboard
      // the values are don't-care because kbX1 masks them.
      if (hPos == KEY_X0) begin
        keyOff <= '0;
        keyIdx <= '0;
        note   <= '0;
      end else if (keyOff == OW'(KEY_W - 1)) begin
        keyOff <= '0;
        if (idx32 < KEY_COUNT) keyIdx <= keyIdx + 1'b1;
        note   <= (note == 3'd6) ? 3'd0 : note + 3'd1;
      end else begin
        keyOff <= keyOff + 1'b1;
      end
    end
  end

  // ---- per-frame input latch / highlight state ----
  logic [7:0]           progLat;
  logic [KEY_COUNT-1:0] whiteHi, blackHi;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n)     progLat <= '0;
    else if (frameTop) progLat <= (iProgress > 8'd100) ? 8'd100 : iProgress;
  end

`ifdef VGA_KEY_HOLD_EN
  // Countdowns step at the same instant the frame latch samples, so a key
  // pressed for one frame stays lit for HOLD_FRAMES frames from that frame.
  for (genvar k = 0; k < KEY_COUNT; k++) begin : gHold
    vga_keyboard_hold #(.HOLD_FRAMES(HOLD_FRAMES)) uHoldW (
      .iClk(iClk), .iReset_n(iReset_n), .iTick(frameTop),
      .iSet(iWhiteMask[k]), .oHi(whiteHi[k]));
    vga_keyboard_hold #(.HOLD_FRAMES(HOLD_FRAMES)) uHoldB (
      .iClk(iClk), .iReset_n(iReset_n), .iTick(frameTop),
      .iSet(iBlackMask[k]), .oHi(blackHi[k]));
  end
`else
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      whiteHi <= '0;
      blackHi <= '0;
    end else if (frameTop) begin
      whiteHi <= iWhiteMask;
      blackHi <= iBlackMask;
    end
  end
`endif

  // ---- stage 2: colour select ----
  // Latched state is consumed here, one cycle after the latch loads, so
  // pixel (0,0) already sees the new frame's values.
  logic          noteR, noteL, blkR, blkL, inWhite, inBlack, isGap;
  logic          whitePick, blackPick, barFill;
  logic [KW-1:0] blkIdx;
  logic [11:0]   rgbNext, rgbReg;

  always_comb begin
    noteR   = (note == 3'd0) || (note == 3'd1) || (note == 3'd3) ||
              (note == 3'd4) || (note == 3'd5);
    noteL   = (note == 3'd1) || (note == 3'd2) || (note == 3'd4) ||
              (note == 3'd5) || (note == 3'd6);
    blkR    = noteR && (off32 >= BLK_R) && (idx32 < KEY_COUNT - 1);
    blkL    = noteL && (off32 < BLK_L) && (idx32 != 32'd0);
    blkIdx  = blkR ? keyIdx : keyIdx - 1'b1;
    inWhite = kbX1 && kbY1;
    inBlack = inWhite && blkY1 && (blkR || blkL);
    isGap   = off32 < KEY_GAP;
    whitePick = 1'b0;
    blackPick = 1'b0;
    for (int k = 0; k < KEY_COUNT; k++) begin
      if (keyIdx == KW'(k)) whitePick = whiteHi[k];
      if (blkIdx == KW'(k)) blackPick = blackHi[k];
    end
    barFill = (32'(barOff1) * 32'd100) < (32'(progLat) * 32'(BAR_W));
    rgbNext = 12'h000;
    if (dePipe[1]) begin
      if (inBlack)      rgbNext = blackPick ? 12'hF80 : 12'h333;
      else if (inWhite) rgbNext = isGap ? 12'h00F : (whitePick ? 12'h0F0 : 12'hFFF);
      else if (bar1)    rgbNext = barFill ? 12'hFF0 : 12'h0F0;
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) rgbReg <= '0;
    else           rgbReg <= rgbNext;
  end

  assign vga.oVGA_Red    = rgbReg[11:8];
  assign vga.oVGA_Green  = rgbReg[7:4];
  assign vga.oVGA_Blue   = rgbReg[3:0];
  assign vga.oDe         = dePipe[STAGES];
  assign vga.oFrameStart = fsPipe[STAGES];
  assign vga.oVGA_Hsync  = hsPipe[STAGES] ? SYNC_POL : ~SYNC_POL;
  assign vga.oVGA_Vsync  = vsPipe[STAGES] ? SYNC_POL : ~SYNC_POL;
endmodule

// File: tb/tb_vga_keyboard_renderer.sv
// Directed bench for vga_keyboard_renderer on a shrunken raster
// (220x28 total, 200x20 visible) with the default horizontal key geometry,
// 8 white keys, keyboard at y=10..17 (black part y=10..13), bar at y=4..6.
module tb_vga_keyboard_renderer;
  localparam int HD = 200, HF = 4, HS = 8, HB = 8;
  localparam int VD = 20,  VF = 2, VS = 3, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int KC = 8;

  logic          iClk = 1'b0;
  logic          iReset_n = 1'b0;
  logic [KC-1:0] iWhiteMask = '0;
  logic [KC-1:0] iBlackMask = '0;
  logic [7:0]    iProgress = '0;

  vga_keyboard_renderer_if vga();

  vga_keyboard_renderer #(
    .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b1), .KEY_COUNT(KC), .KEY_W(19), .KEY_GAP(5),
    .KEY_X0(20), .KEY_Y0(10), .KEY_H(8), .BLACK_W(10), .BLACK_H(4),
    .BAR_X0(20), .BAR_Y0(4), .BAR_W(100), .BAR_H(3), .HOLD_FRAMES(8)
  ) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iWhiteMask(iWhiteMask),
    .iBlackMask(iBlackMask), .iProgress(iProgress), .vga(vga)
  );

  always #5 iClk = ~iClk;

  int nChk = 0, nErr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] rgbNow();
    return {vga.oVGA_Red, vga.oVGA_Green, vga.oVGA_Blue};
  endfunction

  logic [11:0] rgbCap [FR];
  int hsCnt, vsCnt, deCnt, fsCnt, blankBad, hsFirst, vsFirst;

  function automatic int at(input int x, input int y);
    return y * HT + x;
  endfunction

  // Records one frame starting at the current (frame-start) sample; at index
  // chgAt the inputs are switched to the given values.
  task automatic captureFrame(input int chgAt, input logic [KC-1:0] w,
                              input logic [KC-1:0] b, input logic [7:0] p);
    hsCnt = 0; vsCnt = 0; deCnt = 0; fsCnt = 0; blankBad = 0;
    hsFirst = -1; vsFirst = -1;
    for (int n = 0; n < FR; n++) begin
      rgbCap[n] = rgbNow();
      if (vga.oVGA_Hsync) begin hsCnt++; if (hsFirst < 0) hsFirst = n; end
      if (vga.oVGA_Vsync) begin vsCnt++; if (vsFirst < 0) vsFirst = n; end
      if (vga.oDe) deCnt++;
      else if (rgbNow() != 12'h000) blankBad++;
      if (vga.oFrameStart) fsCnt++;
      if (n == chgAt) begin iWhiteMask = w; iBlackMask = b; iProgress = p; end
      @(negedge iClk);
    end
  endtask

  task automatic px(input string tag, input int x, input int y, input logic [11:0] exp);
    chk($sformatf("%s(%0d,%0d)", tag, x, y), 32'(rgbCap[at(x, y)]), 32'(exp));
  endtask

  task automatic checkLatency(input string tag);
    int lat;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge iClk);
      if (vga.oFrameStart) begin lat = i; break; end
    end
    chk(tag, lat, 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge iClk);
    chk("rst hsync", vga.oVGA_Hsync, 0);
    chk("rst vsync", vga.oVGA_Vsync, 0);
    chk("rst rgb",   rgbNow(), 0);
    chk("rst de",    vga.oDe, 0);
    chk("rst fs",    vga.oFrameStart, 0);

    iWhiteMask = 8'h01; iBlackMask = 8'h05; iProgress = 8'd50;
    @(negedge iClk);
    iReset_n = 1'b1;
    checkLatency("fs latency");
    chk("de at (0,0)", vga.oDe, 1);

    // frame 1: W=01 B=05 P=50; inputs change at line 15 (must stay hidden)
    captureFrame(at(0, 15), 8'h02, 8'h05, 8'd200);
    chk("hs count",   hsCnt, HS * VT);
    chk("hs first",   hsFirst, HD + HF);
    chk("vs count",   vsCnt, VS * HT);
    chk("vs first",   vsFirst, (VD + VF) * HT);
    chk("de count",   deCnt, HD * VD);
    chk("blank rgb",  blankBad, 0);
    chk("fs count",   fsCnt, 1);
    chk("fs period",  vga.oFrameStart, 1);
    px("white0 pressed", 25, 10, 12'h0F0);
    px("gap0",           20, 10, 12'h00F);
    px("white1",         44, 10, 12'hFFF);
    px("black0 L",       34, 10, 12'hF80);
    px("black0 R",       39, 10, 12'hF80);
    px("black1 idle",    53, 10, 12'h333);
    px("no black2",      72, 10, 12'hFFF);
    px("gap3",           77, 10, 12'h00F);
    px("below black",    34, 14, 12'h0F0);
    px("last key",      170, 10, 12'hFFF);
    px("past keys",     172, 10, 12'h000);
    px("below kb",       25, 18, 12'h000);
    px("bar fill edge",  69,  4, 12'hFF0);
    px("bar empty edge", 70,  4, 12'h0F0);
    px("bar end 50",    119,  4, 12'h0F0);
    px("past bar",      120,  4, 12'h000);
    px("blank",         205,  5, 12'h000);
    px("old mask k0",    25, 16, 12'h0F0);
    px("old mask k1",    44, 16, 12'hFFF);

    // frame 2: W=02 B=05 P=200 (clamped); change for frame 3 late in frame
    captureFrame(at(0, 19), 8'h02, 8'hC0, 8'd0);
    px("new mask k0",    25, 10, 12'hFFF);
    px("new mask k1",    44, 10, 12'h0F0);
    px("bar clamp",     119,  4, 12'hFF0);
    px("past bar clamp",120,  4, 12'h000);

    // frame 3: W=02 B=C0 P=0
    captureFrame(-1, 8'h00, 8'h00, 8'd0);
    px("bar p0",         20,  4, 12'h0F0);
    px("blk6 ignored",  148, 10, 12'hFFF);
    px("blk7 ignored",  153, 10, 12'h00F);
    px("black0 idle",    34, 10, 12'h333);

    // mid-frame reset at pixel (34,10) of frame 4
    repeat (at(34, 10)) @(negedge iClk);
    chk("pre-reset pixel", rgbNow(), 12'h333);
    iReset_n = 1'b0;
    #1;
    chk("mid rst rgb",  rgbNow(), 0);
    chk("mid rst de",   vga.oDe, 0);
    chk("mid rst hs",   vga.oVGA_Hsync, 0);
    repeat (2) @(negedge iClk);
    iReset_n = 1'b1;
    checkLatency("restart latency");

    captureFrame(-1, 8'h00, 8'h00, 8'd0);
    chk("restart de count", deCnt, HD * VD);
    chk("restart fs count", fsCnt, 1);
    px("restart black0", 34, 10, 12'h333);
    px("restart white1", 44, 10, 12'h0F0);

    $display("Simulation finished: %0d checks, %0d errors", nChk, nErr);
    $finish;
  end
endmodule
